// File: rtl/sim_mon_pkg.sv
// Shared status encoding and default pass-store constants for the write monitor and its benches.
package sim_mon_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PASS    = 2'd1,
        FAIL    = 2'd2,
        TIMEOUT = 2'd3
    } monStatus_t;

    localparam int DEFAULT_PASS_ADR  = 100;
    localparam int DEFAULT_PASS_DATA = 25;

endpackage

// File: rtl/write_history.sv
// Ring log of the last DEPTH stores, write on the clock edge, read combinationally from the newest entry.
// No backpressure: a write is always accepted and overwrites the oldest entry once full.
module write_history #(
    parameter int DEPTH = 8,
    parameter int DW    = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wrEn,
    input  logic [DW-1:0] wrDat,
    input  logic [AW-1:0] rdIdx,
    output logic [DW-1:0] rdDat,
    output logic          rdVld
);

    logic [DW-1:0] ring [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW:0]   fillCount;
    logic [AW-1:0] rdPtr;

    // Contents are left unreset; fillCount gates visibility instead.
    always_ff @(posedge clk) begin
        if (wrEn && !reset) begin
            ring[wrPtr] <= wrDat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr     <= '0;
            fillCount <= '0;
        end else if (wrEn) begin
            wrPtr <= wrPtr + 1'b1;
            if (fillCount != (AW+1)'(DEPTH)) begin
                fillCount <= fillCount + 1'b1;
            end
        end
    end

    assign rdPtr = wrPtr - AW'(1) - rdIdx;
    assign rdDat = ring[rdPtr];
    assign rdVld = ({1'b0, rdIdx} < fillCount);

endmodule

// File: rtl/sim_write_monitor.sv
// Classifies data-memory stores as pass/scratch/illegal, enforces a run timeout and logs recent stores.
// Status updates on the edge that samples the store; no backpressure, the core bus is only snooped.
module sim_write_monitor
    import sim_mon_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter logic [WIDTH-1:0] PASS_ADR       = WIDTH'(DEFAULT_PASS_ADR),
    parameter logic [WIDTH-1:0] PASS_DATA      = WIDTH'(DEFAULT_PASS_DATA),
    parameter logic [WIDTH-1:0] ALLOW_BASE     = '0,
    parameter logic [WIDTH-1:0] ALLOW_MASK     = WIDTH'(32'hFFFF_FF00),
    parameter int               TIMEOUT_CYCLES = 500,
    parameter int               DEPTH          = 8,
    parameter int               CNT_W          = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     MemWrite,
    input  logic [WIDTH-1:0]         DataAdr,
    input  logic [WIDTH-1:0]         WriteData,
    input  logic [$clog2(DEPTH)-1:0] hist_idx,
    output logic                     done,
    output logic [1:0]               status,
    output logic [CNT_W-1:0]         cycle_count,
    output logic [CNT_W-1:0]         write_count,
    output logic [WIDTH-1:0]         fail_adr,
    output logic [WIDTH-1:0]         fail_data,
    output logic [WIDTH-1:0]         hist_adr,
    output logic [WIDTH-1:0]         hist_data,
    output logic                     hist_valid
);

    localparam bit               TIMEOUT_ON = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    monStatus_t        state;
    logic [CNT_W-1:0]  cycleCount;
    logic [CNT_W-1:0]  writeCount;
    logic [WIDTH-1:0]  failAdr;
    logic [WIDTH-1:0]  failData;
    logic              dataHasX;
    logic              storePass;
    logic              storeFail;
    logic              timeoutHit;
    logic              logWrite;
    logic [2*WIDTH-1:0] histDat;

`ifndef SYNTHESIS
    assign dataHasX = $isunknown({DataAdr, WriteData});
`else
    assign dataHasX = 1'b0;
`endif

    // An X/Z strobe falls through the if and is treated as no store.
    always_comb begin
        storePass = 1'b0;
        storeFail = 1'b0;
        if (MemWrite) begin
            if (dataHasX) begin
                storeFail = 1'b1;
            end else if (DataAdr == PASS_ADR) begin
                if (WriteData == PASS_DATA) begin
                    storePass = 1'b1;
                end else begin
                    storeFail = 1'b1;
                end
            end else if ((DataAdr & ALLOW_MASK) != ALLOW_BASE) begin
                storeFail = 1'b1;
            end
        end
    end

    assign timeoutHit = TIMEOUT_ON && (cycleCount == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            cycleCount <= '0;
            writeCount <= '0;
            failAdr    <= '0;
            failData   <= '0;
        end else if (state == RUN) begin
            if (cycleCount != '1) begin
                cycleCount <= cycleCount + 1'b1;
            end
            if (MemWrite && (writeCount != '1)) begin
                writeCount <= writeCount + 1'b1;
            end
            // A store decided on the timeout cycle takes precedence over the timeout.
            if (storePass) begin
                state <= PASS;
            end else if (storeFail) begin
                state    <= FAIL;
                failAdr  <= DataAdr;
                failData <= WriteData;
            end else if (timeoutHit) begin
                state <= TIMEOUT;
            end
        end
    end

    assign logWrite = MemWrite && (state == RUN);

    write_history #(
        .DEPTH (DEPTH),
        .DW    (2*WIDTH)
    ) u_history (
        .clk   (clk),
        .reset (reset),
        .wrEn  (logWrite),
        .wrDat ({DataAdr, WriteData}),
        .rdIdx (hist_idx),
        .rdDat (histDat),
        .rdVld (hist_valid)
    );

    assign hist_adr    = histDat[2*WIDTH-1:WIDTH];
    assign hist_data   = histDat[WIDTH-1:0];
    assign status      = state;
    assign done        = (state != RUN);
    assign cycle_count = cycleCount;
    assign write_count = writeCount;
    assign fail_adr    = failAdr;
    assign fail_data   = failData;

endmodule

// File: tb/tb_sim_write_monitor.sv
// Directed bench for sim_write_monitor: three instances cover default, short-timeout and shallow/no-timeout builds.
module tb_sim_write_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    // Instance A: defaults (timeout 500, depth 8).
    logic        rstA = 1'b1, mwA = 1'b0;
    logic [31:0] adrA = '0, datA = '0;
    logic [2:0]  idxA = '0;
    logic        doneA, validA;
    logic [1:0]  statA;
    logic [15:0] cycA, wcA;
    logic [31:0] fadrA, fdatA, hadrA, hdatA;

    // Instance B: timeout 50.
    logic        rstB = 1'b1, mwB = 1'b0;
    logic [31:0] adrB = '0, datB = '0;
    logic [2:0]  idxB = '0;
    logic        doneB, validB;
    logic [1:0]  statB;
    logic [15:0] cycB, wcB;
    logic [31:0] fadrB, fdatB, hadrB, hdatB;

    // Instance C: timeout disabled, depth 4.
    logic        rstC = 1'b1, mwC = 1'b0;
    logic [31:0] adrC = '0, datC = '0;
    logic [1:0]  idxC = '0;
    logic        doneC, validC;
    logic [1:0]  statC;
    logic [15:0] cycC, wcC;
    logic [31:0] fadrC, fdatC, hadrC, hdatC;

    sim_write_monitor u_dutA (
        .clk(clk), .reset(rstA), .MemWrite(mwA), .DataAdr(adrA), .WriteData(datA),
        .hist_idx(idxA), .done(doneA), .status(statA), .cycle_count(cycA),
        .write_count(wcA), .fail_adr(fadrA), .fail_data(fdatA),
        .hist_adr(hadrA), .hist_data(hdatA), .hist_valid(validA)
    );

    sim_write_monitor #(.TIMEOUT_CYCLES(50)) u_dutB (
        .clk(clk), .reset(rstB), .MemWrite(mwB), .DataAdr(adrB), .WriteData(datB),
        .hist_idx(idxB), .done(doneB), .status(statB), .cycle_count(cycB),
        .write_count(wcB), .fail_adr(fadrB), .fail_data(fdatB),
        .hist_adr(hadrB), .hist_data(hdatB), .hist_valid(validB)
    );

    sim_write_monitor #(.TIMEOUT_CYCLES(0), .DEPTH(4)) u_dutC (
        .clk(clk), .reset(rstC), .MemWrite(mwC), .DataAdr(adrC), .WriteData(datC),
        .hist_idx(idxC), .done(doneC), .status(statC), .cycle_count(cycC),
        .write_count(wcC), .fail_adr(fadrC), .fail_data(fdatC),
        .hist_adr(hadrC), .hist_data(hdatC), .hist_valid(validC)
    );

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic storeA(input logic [31:0] a, input logic [31:0] d);
        mwA = 1'b1; adrA = a; datA = d;
        tick();
        mwA = 1'b0;
    endtask

    task automatic resetA();
        rstA = 1'b1; mwA = 1'b0;
        tick(2);
        rstA = 1'b0;
    endtask

    task automatic resetB();
        rstB = 1'b1; mwB = 1'b0;
        tick(2);
        rstB = 1'b0;
    endtask

    initial begin
        // Reset state
        resetA();
        checkEq("rst_status", 64'(statA), 64'd0);
        checkEq("rst_done", 64'(doneA), 64'd0);
        checkEq("rst_cycle", 64'(cycA), 64'd0);
        checkEq("rst_wcount", 64'(wcA), 64'd0);
        checkEq("rst_failadr", 64'(fadrA), 64'd0);
        checkEq("rst_histvld", 64'(validA), 64'd0);

        // Two scratch stores then the pass store on RUN edge 20
        tick(2);
        storeA(32'h10, 32'd7);
        tick(1);
        storeA(32'h14, 32'd9);
        tick(14);
        checkEq("pre_pass_status", 64'(statA), 64'd0);
        checkEq("pre_pass_cycle", 64'(cycA), 64'd19);
        checkEq("pre_pass_wcount", 64'(wcA), 64'd2);
        storeA(32'd100, 32'd25);
        checkEq("pass_status", 64'(statA), 64'd1);
        checkEq("pass_done", 64'(doneA), 64'd1);
        checkEq("pass_wcount", 64'(wcA), 64'd3);
        checkEq("pass_cycle", 64'(cycA), 64'd20);
        idxA = 3'd0; #1;
        checkEq("pass_hist0_adr", 64'(hadrA), 64'd100);
        checkEq("pass_hist0_dat", 64'(hdatA), 64'd25);
        idxA = 3'd2; #1;
        checkEq("pass_hist2_adr", 64'(hadrA), 64'h10);
        checkEq("pass_hist2_dat", 64'(hdatA), 64'd7);
        checkEq("pass_hist2_vld", 64'(validA), 64'd1);
        idxA = 3'd3; #1;
        checkEq("pass_hist3_vld", 64'(validA), 64'd0);
        tick(3);
        checkEq("pass_cycle_frozen", 64'(cycA), 64'd20);

        // Wrong data at the pass address, later good pass ignored
        resetA();
        storeA(32'd100, 32'd24);
        checkEq("baddata_status", 64'(statA), 64'd2);
        checkEq("baddata_failadr", 64'(fadrA), 64'd100);
        checkEq("baddata_faildat", 64'(fdatA), 64'd24);
        storeA(32'd100, 32'd25);
        checkEq("baddata_sticky", 64'(statA), 64'd2);
        checkEq("baddata_wcount", 64'(wcA), 64'd1);
        checkEq("baddata_faildat2", 64'(fdatA), 64'd24);

        // Store outside the scratch region
        resetA();
        storeA(32'h200, 32'd5);
        checkEq("illegal_status", 64'(statA), 64'd2);
        checkEq("illegal_failadr", 64'(fadrA), 64'h200);
        checkEq("illegal_faildat", 64'(fdatA), 64'd5);

        // Reset mid-run, then pass
        resetA();
        storeA(32'h0, 32'd1);
        storeA(32'h4, 32'd2);
        storeA(32'h8, 32'd3);
        checkEq("mid_wcount", 64'(wcA), 64'd3);
        rstA = 1'b1;
        tick();
        rstA = 1'b0;
        idxA = 3'd0; #1;
        checkEq("mid_rst_status", 64'(statA), 64'd0);
        checkEq("mid_rst_cycle", 64'(cycA), 64'd0);
        checkEq("mid_rst_wcount", 64'(wcA), 64'd0);
        checkEq("mid_rst_histvld", 64'(validA), 64'd0);
        storeA(32'd100, 32'd25);
        checkEq("mid_pass_status", 64'(statA), 64'd1);
        checkEq("mid_pass_wcount", 64'(wcA), 64'd1);

        // Timeout after exactly 50 RUN cycles
        resetB();
        tick(49);
        checkEq("to_pre_status", 64'(statB), 64'd0);
        checkEq("to_pre_cycle", 64'(cycB), 64'd49);
        tick();
        checkEq("to_status", 64'(statB), 64'd3);
        checkEq("to_done", 64'(doneB), 64'd1);
        checkEq("to_cycle", 64'(cycB), 64'd50);
        tick(5);
        checkEq("to_cycle_frozen", 64'(cycB), 64'd50);

        // Pass store on the timeout edge wins
        resetB();
        tick(49);
        mwB = 1'b1; adrB = 32'd100; datB = 32'd25;
        tick();
        mwB = 1'b0;
        checkEq("to_pass_status", 64'(statB), 64'd1);
        checkEq("to_pass_cycle", 64'(cycB), 64'd50);

        // Depth-4 ring wrap and disabled timeout
        rstC = 1'b1;
        tick(2);
        rstC = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mwC = 1'b1; adrC = 32'(4 * i); datC = 32'(i + 1);
            tick();
        end
        mwC = 1'b0;
        checkEq("ring_wcount", 64'(wcC), 64'd6);
        for (int i = 0; i < 4; i++) begin
            idxC = 2'(i); #1;
            checkEq($sformatf("ring_dat%0d", i), 64'(hdatC), 64'(6 - i));
            checkEq($sformatf("ring_adr%0d", i), 64'(hadrC), 64'(32'h14 - 4 * i));
            checkEq($sformatf("ring_vld%0d", i), 64'(validC), 64'd1);
        end
        tick(1000);
        checkEq("notimeout_status", 64'(statC), 64'd0);
        checkEq("notimeout_done", 64'(doneC), 64'd0);
        checkEq("notimeout_cycle", 64'(cycC), 64'd1006);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/sim_write_monitor.md
Name: sim_write_monitor

Overview:
Synthesizable pass/fail monitor for processor system benches. It snoops the data-memory write bus of `top` (MemWrite, DataAdr, WriteData) and classifies each store as pass, allowed scratch write, or illegal. It also enforces a cycle timeout and keeps a small ring log of recent stores for debug. It replaces ad-hoc checking and fixed-delay `$finish` in benches: the bench instantiates it next to `top` and ends simulation on `done`.

Parameters:
- WIDTH, 32, data/address bus width.
- PASS_ADR, 100, store address that signals program completion.
- PASS_DATA, 25, value that must be stored at PASS_ADR for a pass.
- ALLOW_BASE, 0, base of the scratch region where stores are legal.
- ALLOW_MASK, 32'hFFFF_FF00, address mask; a store is legal when (DataAdr & ALLOW_MASK) == ALLOW_BASE.
- TIMEOUT_CYCLES, 500, cycles after reset before TIMEOUT; 0 disables the timeout.
- DEPTH, 8, store-history entries; power of two, at least 2.
- CNT_W, 16, width of the cycle and write counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- MemWrite  in  1  store strobe from the core.
- DataAdr  in  WIDTH  store address.
- WriteData  in  WIDTH  store data.
- hist_idx  in  $clog2(DEPTH)  history read index; 0 = most recent store.
- done  out  1  terminal state reached (sticky).
- status  out  2  0=RUN, 1=PASS, 2=FAIL, 3=TIMEOUT.
- cycle_count  out  CNT_W  cycles spent in RUN.
- write_count  out  CNT_W  stores observed.
- fail_adr  out  WIDTH  address of the failing store.
- fail_data  out  WIDTH  data of the failing store.
- hist_adr  out  WIDTH  logged address at hist_idx.
- hist_data  out  WIDTH  logged data at hist_idx.
- hist_valid  out  1  hist_idx < min(write_count, DEPTH).

Behaviour:
- One clock; reset is synchronous and active-high. Clock port is `clk`, reset port is `reset`.
- Reset (sampled on the clk edge): status=RUN, done=0, counters=0, fail_adr/fail_data=0, history write pointer=0. History contents are don't-care because hist_valid is 0. Reset mid-run aborts everything and restarts in RUN on the next cycle.
- FSM states RUN, PASS, FAIL, TIMEOUT. PASS, FAIL and TIMEOUT are absorbing until reset.
- In RUN, each clk edge:
  - cycle_count increments, saturating at all-ones.
  - If MemWrite=1:
    - write_count increments (saturating).
    - The {DataAdr, WriteData} pair is written into the ring at the pointer; the pointer increments mod DEPTH.
    - Classification, in priority order:
      1. DataAdr==PASS_ADR and WriteData==PASS_DATA → PASS.
      2. DataAdr==PASS_ADR with other data → FAIL.
      3. Legal scratch address → stay in RUN.
      4. Otherwise → FAIL.
    - On FAIL, fail_adr/fail_data capture that store.
  - Timeout: if TIMEOUT_CYCLES≠0 and cycle_count==TIMEOUT_CYCLES-1 with no PASS/FAIL in that cycle → TIMEOUT.
  - If a store and the timeout coincide, the store classification wins.
- Latency: status and done update on the edge that samples the store, so they are visible one cycle after the store is presented.
- Terminal states: counters, fail registers and history are frozen; further MemWrite is ignored.
- Any X/Z on MemWrite is treated as 0. In simulation only, X on DataAdr or WriteData while MemWrite=1 → FAIL.
- History read is combinational: entry = ring[(wptr-1-hist_idx) mod DEPTH]. The index wraps naturally. After more than DEPTH stores, only the last DEPTH are kept.
- done = (status≠RUN).

Decomposition:
- Package `sim_mon_pkg`: the 2-bit status enum (RUN/PASS/FAIL/TIMEOUT) and the default PASS_ADR/PASS_DATA constants shared by benches.
- One sub-module, `write_history`: a parametrised DEPTH×(2·WIDTH) ring buffer with write enable, wrap pointer, count, and combinational indexed read from the newest entry.

Test Plan:
- Stores (0x10,7), (0x14,9), then (100,25) at cycle 20 → status=PASS, done=1 at cycle 21, write_count=3, hist_idx=0 gives (100,25), hist_idx=2 gives (0x10,7).
- Store (100,24) → FAIL; fail_adr=100, fail_data=24; a later (100,25) is ignored and write_count stays frozen.
- Store (0x200,5) with default mask → FAIL, fail_adr=0x200.
- No stores, TIMEOUT_CYCLES=50 → status=TIMEOUT exactly after 50 RUN cycles, cycle_count=50. With TIMEOUT_CYCLES=0, no timeout after 1000 cycles.
- DEPTH=4, six legal stores (0x00..0x14, data 1..6) → hist_idx 0..3 read data 6,5,4,3; hist_valid=1 for all; write_count=6.
- Edge cases:
  - Pass store on the timeout cycle → PASS.
  - reset pulsed after 3 stores → counters=0, hist_valid=0, status=RUN; the next pass store still yields PASS.
